equiv_stim_driver: RTL and testbench
====================================

// Module: equiv_stim_driver
// PURPOSE
//  Drives the DUT control inputs of the dual-subsystem equivalence harness.
//  One driver output pair feeds both Subsystem copies identically; the checker at the other end
//  compares Hdl_out_1/Hdl_out_2 each cycle.
//  Sequences a DUT reset phase, a pseudo-random clk_enable run phase and a flush phase, then signals done.
//  Optional one-cycle DUT reset injection mid-run exercises reset recovery in both copies.
// PARAMETERS
//  RESET_CYCLES  4    cycles dut_reset is held high in RESET state (>=1)
//  RUN_CYCLES    256  cycles spent in RUN state (>=1)
//  DRAIN_CYCLES  8    cycles of forced clk_enable=1 in DRAIN state (>=1)
//  CNT_W         16   width of enabled_count
// PORTS
//  clk             in   1      single clock; all logic on posedge
//  reset           in   1      synchronous, active-high
//  start           in   1      begin a sequence; sampled only in IDLE
//  seed            in   16     LFSR seed, latched on accepted start
//  density         in   2      clk_enable density: 00=100%, 01=75%, 10=50%, 11=25%
//  inject_reset    in   1      request a one-cycle DUT reset pulse; honoured only in RUN
//  dut_reset       out  1      to reset of both Subsystem copies
//  dut_clk_enable  out  1      to clk_enable of both Subsystem copies
//  busy            out  1      high in RESET/RUN/DRAIN
//  done            out  1      one-cycle pulse at end of sequence
//  enabled_count   out  CNT_W  RUN cycles with dut_clk_enable=1; saturates at all-ones
//  phase           out  3      current state encoding (IDLE=0,RESET=1,RUN=2,DRAIN=3,DONE=4)
// BEHAVIOUR
//  - All outputs are registered. Reset values: state IDLE, dut_reset=1, dut_clk_enable=0,
//    busy=0, done=0, enabled_count=0, LFSR=16'h0001.
//  - Reset mid-sequence: abort to IDLE on the next edge, with reset values as above.
//    No done pulse is issued for an aborted sequence.
//  - IDLE: dut_reset=1, dut_clk_enable=0.
//    start=1 at edge t -> state RESET from t+1. On acceptance:
//    latch density; load LFSR with seed (seed==0 loads 16'h0001); clear enabled_count.
//  - RESET: dut_reset=1, dut_clk_enable=0 for exactly RESET_CYCLES cycles, then RUN.
//  - RUN: exactly RUN_CYCLES cycles, then DRAIN.
//    dut_reset=0; dut_clk_enable decided from LFSR bits b=[1:0]:
//    00 -> 1; 01 -> (b!=2'b00); 10 -> b[0]; 11 -> (b==2'b11).
//    LFSR: 16-bit Galois, shift right, XOR taps 16'hB400 when shifted-out bit=1.
//    It advances once per RUN cycle, so the sequence is deterministic per seed.
//    enabled_count increments for each RUN cycle with dut_clk_enable=1.
//  - inject_reset=1 in a RUN cycle -> the next RUN cycle has dut_reset=1 and dut_clk_enable=0.
//    That cycle still counts toward RUN_CYCLES, and the LFSR still advances.
//    Requests during that pulse cycle are ignored.
//    A request in the last RUN cycle is dropped (no pulse in DRAIN).
//  - DRAIN: dut_reset=0, dut_clk_enable=1 for DRAIN_CYCLES cycles; enabled_count frozen.
//  - DONE: done=1, busy=0, dut_clk_enable=0 for one cycle, then IDLE.
//    A start during DONE is ignored.
//  - start while busy: ignored.
//    density/seed changes mid-sequence: no effect (latched values used).
//  - Timeline for start accepted at t: RESET t+1..t+R; RUN t+R+1..t+R+N;
//    DRAIN ..t+R+N+D; done at t+R+N+D+1.
// STRUCTURE
//  - Package equiv_harness_pkg holds:
//    state enum and phase codes; density codes; LFSR_TAPS=16'hB400; LFSR_SEED_DEFAULT=16'h0001.
//  - Sub-module equiv_lfsr16 (load, advance, seed, value); FSM, counters and output regs in top.
//  - One cycle counter sized for max(RESET_CYCLES, RUN_CYCLES, DRAIN_CYCLES), reloaded per state.
// TESTING
//  1 Assert reset 3 cycles -> dut_reset=1, dut_clk_enable=0, busy=0, done=0, enabled_count=0, phase=0.
//  2 Defaults, density=00, start at t -> dut_reset=1 over t+1..t+4; dut_clk_enable=1 over t+5..t+268;
//    done pulse at t+269; enabled_count=256.
//  3 density=10, seed=16'h0001, run twice -> identical dut_clk_enable traces;
//    enabled_count equals a software Galois model count.
//  4 density=00, inject_reset at RUN cycle 100 -> RUN cycle 101 has dut_reset=1, enable=0;
//    done still at t+269; enabled_count=255.
//  5 seed=0 -> behaves identically to seed=16'h0001;
//    start pulsed during RUN -> no restart, single done.
//  6 reset asserted mid-RUN -> IDLE next cycle, dut_reset=1, enable=0;
//    no done pulse; a fresh start then runs a full sequence.

Source files
------------

// File: rtl/equiv_harness_pkg.sv
// Shared types and constants for the equivalence-harness stimulus driver.
// Phase codes double as the state encoding presented on the phase output.
package equiv_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DENS_100 = 2'b00,
    DENS_75  = 2'b01,
    DENS_50  = 2'b10,
    DENS_25  = 2'b11
  } density_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

  // Galois form: shift right, fold taps in when a one falls out of bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

  function automatic logic density_gate(input density_t d, input logic [1:0] b);
    logic g;
    case (d)
      DENS_100: g = 1'b1;
      DENS_75:  g = (b != 2'b00);
      DENS_50:  g = b[0];
      default:  g = (b == 2'b11);
    endcase
    return g;
  endfunction

endpackage

// File: rtl/equiv_lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed falls back to the default
// so the register can never lock up at all-zeros.
module equiv_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  import equiv_harness_pkg::*;

  logic [15:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      r_value <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
    end else if (advance) begin
      r_value <= lfsr_step(r_value);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/equiv_stim_driver.sv
// Sequences DUT reset, pseudo-random clk_enable run and drain phases for both
// Subsystem copies of the equivalence harness, then pulses done.
module equiv_stim_driver #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned RUN_CYCLES   = 256,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [1:0]       density,
  input  logic             inject_reset,
  output logic             dut_reset,
  output logic             dut_clk_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] enabled_count,
  output logic [2:0]       phase
);
  import equiv_harness_pkg::*;

  localparam int unsigned MAX_LEN_RR = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int unsigned MAX_LEN    = (MAX_LEN_RR > DRAIN_CYCLES) ? MAX_LEN_RR : DRAIN_CYCLES;
  localparam int unsigned CYC_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CYC_W-1:0]   r_cyc;
  logic [CYC_W-1:0]   w_cyc_nx;
  density_t           r_density;
  logic               r_dut_reset;
  logic               r_en;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        w_lfsr;
  logic               w_load;
  logic               w_advance;
  logic               w_gate;
  logic               w_pulse;
  logic               w_rst_nx;
  logic               w_en_nx;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_advance = (w_state_nx == ST_RUN);

  equiv_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .advance (w_advance),
    .seed    (seed),
    .value   (w_lfsr)
  );

  // Counter holds cycles remaining minus one; reloaded on every state entry.
  always_comb begin
    w_state_nx = r_state;
    w_cyc_nx   = r_cyc - 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_cyc_nx = r_cyc;
        if (start) begin
          w_state_nx = ST_RESET;
          w_cyc_nx   = CYC_W'(RESET_CYCLES - 1);
        end
      end
      ST_RESET: if (r_cyc == '0) begin
        w_state_nx = ST_RUN;
        w_cyc_nx   = CYC_W'(RUN_CYCLES - 1);
      end
      ST_RUN: if (r_cyc == '0) begin
        w_state_nx = ST_DRAIN;
        w_cyc_nx   = CYC_W'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN: if (r_cyc == '0) begin
        w_state_nx = ST_DONE;
        w_cyc_nx   = '0;
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
        w_cyc_nx   = '0;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cyc_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with phase.
  // r_dut_reset high while in RUN marks the injected pulse cycle.
  always_comb begin
    w_gate   = density_gate(r_density, w_lfsr[1:0]);
    w_pulse  = (r_state == ST_RUN) && (w_state_nx == ST_RUN) && inject_reset && !r_dut_reset;
    w_rst_nx = 1'b1;
    w_en_nx  = 1'b0;
    case (w_state_nx)
      ST_RUN: begin
        w_rst_nx = w_pulse;
        w_en_nx  = !w_pulse && w_gate;
      end
      ST_DRAIN: begin
        w_rst_nx = 1'b0;
        w_en_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cyc       <= '0;
      r_density   <= DENS_100;
      r_dut_reset <= 1'b1;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cyc       <= w_cyc_nx;
      r_dut_reset <= w_rst_nx;
      r_en        <= w_en_nx;
      r_busy      <= (w_state_nx == ST_RESET) || (w_state_nx == ST_RUN) || (w_state_nx == ST_DRAIN);
      r_done      <= (w_state_nx == ST_DONE);
      if (w_load) begin
        r_density <= density_t'(density);
        r_count   <= '0;
      end else if ((w_state_nx == ST_RUN) && w_en_nx && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign dut_reset      = r_dut_reset;
  assign dut_clk_enable = r_en;
  assign busy           = r_busy;
  assign done           = r_done;
  assign enabled_count  = r_count;
  assign phase          = r_state;

endmodule

// File: tb/tb_equiv_stim_driver.sv
// Self-checking bench for equiv_stim_driver: vector table plus per-cycle
// expected-trace scoreboard built from an independent LFSR model.
module tb_equiv_stim_driver;

  localparam int R     = 4;
  localparam int N     = 256;
  localparam int D     = 8;
  localparam int TOTAL = R + N + D + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] seed;
  logic [1:0]  density;
  logic        inject_reset;
  logic        dut_reset;
  logic        dut_clk_enable;
  logic        busy;
  logic        done;
  logic [15:0] enabled_count;
  logic [2:0]  phase;

  equiv_stim_driver #(
    .RESET_CYCLES (R),
    .RUN_CYCLES   (N),
    .DRAIN_CYCLES (D),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .density        (density),
    .inject_reset   (inject_reset),
    .dut_reset      (dut_reset),
    .dut_clk_enable (dut_clk_enable),
    .busy           (busy),
    .done           (done),
    .enabled_count  (enabled_count),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       bsy;
    logic       dn;
    logic [2:0] ph;
  } obs_t;

  typedef struct {
    logic [15:0] seed;
    logic [1:0]  dens;
    int          inj;       // RUN cycle index carrying inject_reset, -1 none
    int          start_at;  // cycle offset carrying a stray start, 0 none
    int          exp_cnt;   // -1: take the count from the model
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic m_gate(input logic [1:0] d, input logic [1:0] b);
    if (d == 2'b00) return 1'b1;
    if (d == 2'b01) return b != 2'b00;
    if (d == 2'b10) return b[0];
    return b == 2'b11;
  endfunction

  task automatic push_expected(input vec_t v, output int cnt);
    logic [15:0] s;
    obs_t        o;
    s   = (v.seed == 16'h0000) ? 16'h0001 : v.seed;
    cnt = 0;
    for (int c = 0; c < R; c++) sb_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'd1});
    for (int k = 0; k < N; k++) begin
      if (v.inj >= 0 && k == v.inj + 1) begin
        o = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2};
      end else begin
        o = '{1'b0, m_gate(v.dens, s[1:0]), 1'b1, 1'b0, 3'd2};
        if (o.en) cnt++;
      end
      sb_q.push_back(o);
      s = m_next(s);
    end
    for (int c = 0; c < D; c++) sb_q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd3});
    sb_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd4});
    sb_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int   mcnt;
    obs_t exp;
    obs_t act;
    @(posedge clk); #1;
    seed    = v.seed;
    density = v.dens;
    start   = 1'b1;
    push_expected(v, mcnt);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= TOTAL; c++) begin
      @(negedge clk);
      act = '{dut_reset, dut_clk_enable, busy, done, phase};
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_queue_empty_c%0d", idx, c), 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check($sformatf("v%0d_trace_c%0d", idx, c), 32'(act), 32'(exp));
      end
      if (c == R + N + D + 1)
        check($sformatf("v%0d_enabled_count", idx), 32'(enabled_count),
              (v.exp_cnt >= 0) ? v.exp_cnt : mcnt);
      @(posedge clk); #1;
      inject_reset = (v.inj >= 0) && (c + 1 == R + 1 + v.inj);
      start        = (v.start_at > 0) && (c + 1 == v.start_at);
      if (c + 1 == R + 11) begin
        density = density ^ 2'b11;
        seed    = ~seed;
      end
    end
    inject_reset = 1'b0;
    start        = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int dn_seen;
    reset = 1'b1; start = 1'b0; seed = 16'h0001; density = 2'b00; inject_reset = 1'b0;

    vecs[0] = '{16'h0001, 2'b00, -1, 0, 256};
    vecs[1] = '{16'h0001, 2'b10, -1, 0, -1};
    vecs[2] = '{16'h0001, 2'b10, -1, 0, -1};
    vecs[3] = '{16'h0001, 2'b00, 100, 0, 255};
    vecs[4] = '{16'h0000, 2'b10, -1, R + 1 + 50, -1};
    vecs[5] = '{16'hACE1, 2'b01, -1, R + N + D + 1, -1};
    vecs[6] = '{16'h1234, 2'b11, N - 1, 0, -1};
    vecs[7] = '{16'hBEEF, 2'b01, 0, 0, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dut_reset", 32'(dut_reset), 32'd1);
    check("rst_clk_enable", 32'(dut_clk_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(enabled_count), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

    // Abort mid-RUN via reset, expect immediate IDLE and no done pulse.
    @(posedge clk); #1;
    seed = 16'h0001; density = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (R + 20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_dut_reset", 32'(dut_reset), 32'd1);
    check("abort_clk_enable", 32'(dut_clk_enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(enabled_count), 32'd0);
    dn_seen = 0;
    for (int c = 0; c < N + D + 10; c++) begin
      @(negedge clk);
      if (done) dn_seen++;
    end
    check("abort_no_done", 32'(dn_seen), 32'd0);
    run_vector(vecs[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
